// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: prefix codes, frame FSM encoding and the key event record.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
  localparam logic [7:0] PS2_BRK_CODE = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event FIFO with ready/valid pop and a one-cycle overflow pulse.
module ps2_evt_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ready,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             pop;
  logic             wr_en;

  assign valid = (count != '0);
  assign full  = (count == FULL_CNT);
  assign pop   = valid & ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign wr_en = push & (~full | pop);
  assign rdata = valid ? mem[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
      ovf   <= push & ~wr_en;
    end
  end

  // NOTE: storage has no reset; rdata is masked while empty so stale contents never leak out.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: pin filtering, 11-bit frame check, timeout recovery,
// make/break/extended decode and a ready/valid key event FIFO.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_US  = 2000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       CLK_50M,
  input  logic       RST_N,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] o_key_code,
  output logic       o_key_ext,
  output logic       o_key_break,
  output logic       o_key_valid,
  input  logic       i_key_ready,
  output logic       o_parity_err,
  output logic       o_timeout_err,
  output logic       o_fifo_ovf
);

  localparam int              TO_CYC  = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int              TO_W    = $clog2(TO_CYC + 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TO_CYC);
  localparam int              FLT_W   = $clog2(FILTER_LEN);
  localparam logic [FLT_W-1:0] FLT_MAX = FLT_W'(FILTER_LEN - 1);

  // Index 0 is PS2_CLK, index 1 is PS2_DATA; everything resets to the idle-high bus level.
  logic [1:0]       pin_meta;
  logic [1:0]       pin_sync;
  logic [1:0]       pin_filt;
  logic [FLT_W-1:0] flt_cnt [2];
  logic             clk_prev;
  logic             fe;
  logic             ps2_bit;

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      pin_meta <= 2'b11;
      pin_sync <= 2'b11;
      pin_filt <= 2'b11;
      clk_prev <= 1'b1;
      for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
    end else begin
      pin_meta <= {PS2_DATA, PS2_CLK};
      pin_sync <= pin_meta;
      clk_prev <= pin_filt[0];
      for (int i = 0; i < 2; i++) begin
        if (pin_sync[i] == pin_filt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == FLT_MAX) begin
          pin_filt[i] <= pin_sync[i];
          flt_cnt[i]  <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign fe      = clk_prev & ~pin_filt[0];
  assign ps2_bit = pin_filt[1];

  frame_state_t    state;
  frame_state_t    state_nxt;
  logic [7:0]      shift;
  logic [2:0]      bit_cnt;
  logic            par_ok;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            start_err;
  logic            stop_err;
  logic            byte_done;

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    if (to_hit) begin
      state_nxt = ST_IDLE;
    end else if (fe) begin
      case (state)
        ST_IDLE:   if (!ps2_bit) state_nxt = ST_DATA;
        ST_DATA:   if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
        ST_PARITY: state_nxt = ST_STOP;
        ST_STOP:   state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    to_hit    = (state != ST_IDLE) && (to_cnt == TO_MAX) && !fe;
    start_err = fe && (state == ST_IDLE) && ps2_bit;
    stop_err  = fe && (state == ST_STOP) && !(par_ok && ps2_bit);
    byte_done = fe && (state == ST_STOP) && par_ok && ps2_bit;
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      shift   <= '0;
      bit_cnt <= '0;
      par_ok  <= 1'b0;
      to_cnt  <= '0;
    end else begin
      if (state == ST_IDLE || fe)  to_cnt <= '0;
      else if (to_cnt != TO_MAX)   to_cnt <= to_cnt + 1'b1;
      if (fe) begin
        case (state)
          ST_IDLE:   bit_cnt <= '0;
          ST_DATA: begin
            shift   <= {ps2_bit, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          ST_PARITY: par_ok <= ^{shift, ps2_bit};
          default:   ;
        endcase
      end
    end
  end

  // Prefix bytes only arm flags; any other good byte becomes an event and clears them.
  key_evt_t evt_q;
  logic     push_q;
  logic     ext_flag;
  logic     brk_flag;

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      evt_q         <= '0;
      push_q        <= 1'b0;
      ext_flag      <= 1'b0;
      brk_flag      <= 1'b0;
      o_parity_err  <= 1'b0;
      o_timeout_err <= 1'b0;
    end else begin
      push_q        <= 1'b0;
      o_parity_err  <= start_err | stop_err;
      o_timeout_err <= to_hit;
      if (to_hit || stop_err) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (byte_done) begin
        if (shift == PS2_EXT_CODE) begin
          ext_flag <= 1'b1;
        end else if (shift == PS2_BRK_CODE) begin
          brk_flag <= 1'b1;
        end else begin
          push_q     <= 1'b1;
          evt_q.ext  <= ext_flag;
          evt_q.brk  <= brk_flag;
          evt_q.code <= shift;
          ext_flag   <= 1'b0;
          brk_flag   <= 1'b0;
        end
      end
    end
  end

  key_evt_t head;

  ps2_evt_fifo #(
    .WIDTH($bits(key_evt_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK_50M),
    .rst_n (RST_N),
    .push  (push_q),
    .wdata (evt_q),
    .ready (i_key_ready),
    .rdata (head),
    .valid (o_key_valid),
    .ovf   (o_fifo_ovf)
  );

  assign o_key_code  = head.code;
  assign o_key_ext   = head.ext;
  assign o_key_break = head.brk;

endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
Parametrised successor to the team's PS/2 keyboard receiver.
- Adds: glitch-filtered PS2_CLK/PS2_DATA, full 11-bit frame checking (start/odd-parity/stop), inter-bit timeout recovery, make/break/extended decode into 10-bit key events, and a ready/valid event FIFO.
- Sits between the PS/2 pins and consumers (display, UART bridge); replaces the 16-bit last-key register output.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency.
- FILTER_LEN, 8, consecutive identical samples needed to accept a level change on PS2_CLK/PS2_DATA (2..32).
- TIMEOUT_US, 2000, maximum time between PS2_CLK falling edges inside a frame.
- FIFO_DEPTH, 4, key-event FIFO entries (power of 2, >=2).

Ports:
- CLK_50M  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- PS2_CLK  in  1  PS/2 clock pin, asynchronous
- PS2_DATA  in  1  PS/2 data pin, asynchronous
- o_key_code  out  8  scan code of head event
- o_key_ext  out  1  head event had an E0 prefix
- o_key_break  out  1  head event had an F0 prefix (key released)
- o_key_valid  out  1  FIFO non-empty
- i_key_ready  in  1  consumer accepts the head event when valid&ready
- o_parity_err  out  1  one-cycle pulse on a frame error (parity, start or stop)
- o_timeout_err  out  1  one-cycle pulse on frame timeout
- o_fifo_ovf  out  1  one-cycle pulse when an event is dropped because the FIFO is full

Behaviour:
- Reset: every output is 0; FSM in IDLE; FIFO empty; prefix flags cleared; filters preset to 1 (bus idle). Reset mid-frame discards the partial frame.
- Input conditioning:
  - 2-flop synchroniser per pin, then a saturating filter. The filtered level changes only after FILTER_LEN consecutive equal synchronised samples.
  - Falling-edge pulse fe = one cycle when filtered CLK goes 1->0. Data is sampled from filtered DATA on the fe cycle.
- Frame FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE. Each transition advances only on fe.
  - IDLE: on fe, sampled bit must be 0 (start). If 1, stay IDLE and pulse o_parity_err.
  - DATA: 8 bits, LSB first, shifted into an 8-bit register; a 3-bit counter selects the exit to PARITY.
  - PARITY: data bits plus parity bit must have odd weight.
  - STOP: bit must be 1. On the stop fe: if parity and stop are good, the frame is done (byte_done pulse); otherwise pulse o_parity_err and clear the prefix flags.
- Timeout:
  - Counter limit TO_CYC = CLK_FREQ_HZ/1000000*TIMEOUT_US; counter width $clog2(TO_CYC+1).
  - Counter clears on every fe and is held at 0 in IDLE.
  - When it reaches TO_CYC outside IDLE: go to IDLE, pulse o_timeout_err, clear the prefix flags, emit no event.
- Decode (on byte_done):
  - 0xE0 sets ext_flag.
  - 0xF0 sets brk_flag.
  - Any other byte pushes the event {ext_flag, brk_flag, byte} and clears both flags.
  - 0xE1/Pause bytes get no special handling; they pass as ordinary codes.
- FIFO:
  - First-word-fall-through; data outputs are valid whenever o_key_valid is 1.
  - Push happens the cycle after byte_done. o_key_valid rises 2 cycles after the stop-bit fe when the FIFO was empty.
  - Pop when o_key_valid & i_key_ready.
  - Full: a push without a simultaneous pop is dropped and o_fifo_ovf pulses. Push and pop together when full: both are accepted and the count is unchanged.
  - Empty: ready is ignored.
  - Pointers wrap modulo FIFO_DEPTH; the count is $clog2(FIFO_DEPTH)+1 bits.
  - Outputs hold stable while valid & !ready.
- Error pulses never coincide with a FIFO push for the same frame.

Decomposition:
- Package ps2_pkg holds:
  - constants PS2_EXT_CODE=8'hE0 and PS2_BRK_CODE=8'hF0
  - the frame FSM state encoding
  - the key event record layout: 10 bits, {ext, brk, code[7:0]}
- Sub-module ps2_evt_fifo: parametrised FWFT FIFO with ready/valid handshake and an overflow pulse. It is reusable by the UART and IR blocks.
- Filter, FSM, timeout and decode stay in ps2_scan_decoder.

Test Plan:
- Valid frame, byte 0x1C at 12.5 kHz PS2_CLK -> one event: code=0x1C, ext=0, brk=0, valid 2 cycles after the stop edge; no error pulses.
- Sequence E0 F0 75, then F0 1C -> two events, in order: {ext=1, brk=1, code=0x75}, then {ext=0, brk=1, code=0x1C}.
- Byte 0x1C with the parity bit inverted -> o_parity_err pulses once, no event. A following good 0x1C gives code=0x1C with ext=0 and brk=0 (flags cleared).
- Only 5 bits sent, then the clock is held high -> o_timeout_err pulses TO_CYC cycles after the last fe (100000 cycles at the default parameters), FSM in IDLE. The next full 0x29 frame decodes correctly.
- i_key_ready=0 while 5 make codes 0x01..0x05 arrive (FIFO_DEPTH=4) -> o_fifo_ovf pulses once on 0x05. Raising ready drains 0x01..0x04 in order, then o_key_valid=0.
- 3-cycle low glitch on PS2_CLK (FILTER_LEN=8) mid-frame -> no bit counted; the frame still decodes to the correct byte.
